// File: rtl/uart_tx_ctrl.sv
// uart_tx_ctrl: UART transmit sequencer, one frame per valid/ready accept.
// Frame = start, DATA_BITS data (LSB first), optional parity, one stop bit.
//
// Ports:
//   clk, rst       clock and synchronous active-high reset
//   tx_data        frame payload, latched on accept
//   tx_valid       frame request
//   tx_ready       idle and not in reset
//   baud_div       clocks per bit minus 1, latched on accept
//   parity_en      append parity bit, latched on accept
//   parity_odd     1 = odd, 0 = even parity, latched on accept
//   tx             registered serial line, idles high
//   busy           high from first start-bit cycle to last stop-bit cycle
//   done           one-cycle pulse in the first idle cycle after stop
module uart_tx_ctrl #(
  parameter int DATA_BITS = 8,
  parameter int DIV_W     = 16,
  parameter int BIT_W     = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  input  logic [DIV_W-1:0]     baud_div,
  input  logic                 parity_en,
  input  logic                 parity_odd,
  output logic                 tx,
  output logic                 busy,
  output logic                 done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t               state_q, state_d;
  logic [DIV_W-1:0]     div_q, div_d;
  logic [DIV_W-1:0]     pre_q, pre_d;
  logic [BIT_W-1:0]     bit_q, bit_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 par_en_q, par_en_d;
  logic                 par_odd_q, par_odd_d;
  logic                 tx_q, tx_d;
  logic                 done_q, done_d;

  logic                 accept;
  logic                 tick;
  logic                 last_bit;
  logic [DATA_BITS-1:0] data_sh;

  assign tx_ready = (state_q == S_IDLE) && !rst;
  assign accept   = tx_valid && tx_ready;
  assign tick     = (pre_q == div_q);
  assign last_bit = (bit_q == BIT_W'(DATA_BITS - 1));

  assign tx   = tx_q;
  assign busy = (state_q != S_IDLE);
  assign done = done_q;

  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    bit_d     = bit_q;
    data_d    = data_q;
    par_en_d  = par_en_q;
    par_odd_d = par_odd_q;
    done_d    = 1'b0;

    // Prescaler free-runs 0..div_q while a frame is active.
    if (state_q == S_IDLE || tick) begin
      pre_d = '0;
    end else begin
      pre_d = pre_q + DIV_W'(1);
    end

    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d   = S_START;
          div_d     = baud_div;
          data_d    = tx_data;
          par_en_d  = parity_en;
          par_odd_d = parity_odd;
          bit_d     = '0;
          pre_d     = '0;
        end
      end
      S_START: begin
        if (tick) begin
          state_d = S_DATA;
          bit_d   = '0;
        end
      end
      S_DATA: begin
        if (tick) begin
          if (last_bit) begin
            state_d = par_en_q ? S_PARITY : S_STOP;
          end else begin
            bit_d = bit_q + BIT_W'(1);
          end
        end
      end
      S_PARITY: begin
        if (tick) begin
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (tick) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Line value follows the next state so tx changes on the same
  // edge as the state register.
  assign data_sh = data_d >> bit_d;

  always_comb begin
    tx_d = 1'b1;
    unique case (state_d)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = data_sh[0];
      S_PARITY: tx_d = (^data_q) ^ par_odd_q;
      default:  tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      div_q     <= '0;
      pre_q     <= '0;
      bit_q     <= '0;
      data_q    <= '0;
      par_en_q  <= 1'b0;
      par_odd_q <= 1'b0;
      tx_q      <= 1'b1;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      pre_q     <= pre_d;
      bit_q     <= bit_d;
      data_q    <= data_d;
      par_en_q  <= par_en_d;
      par_odd_q <= par_odd_d;
      tx_q      <= tx_d;
      done_q    <= done_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// tb_uart_tx_ctrl: scoreboard bench for uart_tx_ctrl.
// Line is captured per cycle while busy and checked at each done pulse.
module tb_uart_tx_ctrl;

  logic        clk;
  logic        rst;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [15:0] baud_div;
  logic        parity_en;
  logic        parity_odd;
  logic        tx;
  logic        busy;
  logic        done;

  uart_tx_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .baud_div   (baud_div),
    .parity_en  (parity_en),
    .parity_odd (parity_odd),
    .tx         (tx),
    .busy       (busy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  d;
    logic [15:0] div;
    logic        pe;
    logic        po;
  } exp_t;

  exp_t exp_q[$];
  logic cap[$];
  int   n_chk;
  int   n_fail;
  bit   armed;
  bit   prev_busy;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", tag, got, want);
    end
  endtask

  function automatic void push_exp(input logic [7:0] d,
                                   input logic [15:0] div,
                                   input logic pe,
                                   input logic po);
    exp_t e;
    e.d   = d;
    e.div = div;
    e.pe  = pe;
    e.po  = po;
    exp_q.push_back(e);
  endfunction

  task automatic check_frame(input exp_t e);
    logic ebit[$];
    int   w;
    logic obs;
    w = int'(e.div) + 1;
    ebit.push_back(1'b0);
    for (int i = 0; i < 8; i++) ebit.push_back(e.d[i]);
    if (e.pe) ebit.push_back((^e.d) ^ e.po);
    ebit.push_back(1'b1);
    chk("frame_len", cap.size(), ebit.size() * w);
    if (cap.size() == ebit.size() * w) begin
      for (int b = 0; b < ebit.size(); b++) begin
        obs = ebit[b];
        for (int j = 0; j < w; j++)
          if (cap[b*w+j] !== ebit[b]) obs = cap[b*w+j];
        chk($sformatf("d%0h_bit%0d", e.d, b), obs, ebit[b]);
      end
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (armed) begin
      if (rst) begin
        if (cap.size() > 0) begin
          if (exp_q.size() > 0) e = exp_q.pop_front();
          cap.delete();
        end
        prev_busy = 1'b0;
      end else begin
        if (busy) begin
          cap.push_back(tx);
        end else if (done) begin
          chk("done_after_stop", prev_busy, 1);
          chk("done_has_frame", exp_q.size() > 0, 1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check_frame(e);
          end
          cap.delete();
        end
        prev_busy = busy;
      end
    end
  end

  task automatic send(input logic [7:0] d,
                      input logic [15:0] div,
                      input logic pe,
                      input logic po,
                      input bit hold);
    int n;
    tx_data    = d;
    baud_div   = div;
    parity_en  = pe;
    parity_odd = po;
    tx_valid   = 1'b1;
    n = 0;
    @(negedge clk);
    while (!tx_ready && n < 200000) begin
      n++;
      @(negedge clk);
    end
    if (!tx_ready) begin
      $display("FAIL send_timeout: got ready 0 want 1");
      n_fail++;
      $fatal(1, "no accept");
    end
    @(posedge clk);
    push_exp(d, div, pe, po);
    #1;
    if (!hold) tx_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < 200000) begin
      @(negedge clk);
      n++;
    end
    chk("drain", exp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    n_chk      = 0;
    n_fail     = 0;
    armed      = 1'b0;
    prev_busy  = 1'b0;
    rst        = 1'b1;
    tx_valid   = 1'b1;
    tx_data    = 8'h81;
    baud_div   = 16'd1;
    parity_en  = 1'b0;
    parity_odd = 1'b0;

    // Reset with a pending request: nothing may start.
    @(posedge clk);
    #1;
    armed = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_tx", tx, 1);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_ready", tx_ready, 0);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", tx_ready, 1);
    chk("post_rst_busy", busy, 0);
    @(posedge clk);
    push_exp(8'h81, 16'd1, 1'b0, 1'b0);
    #1;
    tx_valid = 1'b0;
    @(negedge clk);
    chk("first_start_busy", busy, 1);
    chk("first_start_tx", tx, 0);
    wait_idle();

    // Basic frame and parity variants.
    send(8'hA5, 16'd3, 1'b0, 1'b0, 1'b0);
    wait_idle();
    send(8'h07, 16'd0, 1'b1, 1'b0, 1'b0);
    wait_idle();
    send(8'h07, 16'd0, 1'b1, 1'b1, 1'b0);
    wait_idle();

    // Back-to-back with data changed while first frame is in flight.
    send(8'h55, 16'd1, 1'b0, 1'b0, 1'b1);
    tx_data   = 8'hAA;
    parity_en = 1'b1;
    baud_div  = 16'd7;
    @(posedge clk);
    #1;
    parity_en = 1'b0;
    baud_div  = 16'd1;
    n = 0;
    @(negedge clk);
    while (!done && n < 1000) begin
      n++;
      @(negedge clk);
    end
    chk("b2b_done_seen", done, 1);
    chk("b2b_gap_tx", tx, 1);
    chk("b2b_ready", tx_ready, 1);
    @(posedge clk);
    push_exp(8'hAA, 16'd1, 1'b0, 1'b0);
    #1;
    tx_valid = 1'b0;
    @(negedge clk);
    chk("b2b_busy", busy, 1);
    chk("b2b_start", tx, 0);
    wait_idle();

    // Reset during data bit 3 aborts the frame.
    send(8'hC3, 16'd1, 1'b0, 1'b0, 1'b0);
    repeat (8) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("abort_tx", tx, 1);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("abort_no_done", done, 0);
    end
    @(posedge clk);
    #1;
    send(8'h3C, 16'd2, 1'b1, 1'b1, 1'b0);
    wait_idle();

    // Largest divisor: measure the start bit only, then abort.
    send(8'h3D, 16'hFFFF, 1'b0, 1'b0, 1'b0);
    n = 0;
    @(negedge clk);
    while (tx === 1'b0 && n < 70000) begin
      n++;
      @(negedge clk);
    end
    chk("maxdiv_start_w", n, 65536);
    chk("maxdiv_bit0", tx, 1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("maxdiv_abort_tx", tx, 1);
    chk("maxdiv_abort_busy", busy, 0);

    send(8'h5A, 16'd0, 1'b0, 1'b0, 1'b0);
    wait_idle();
    repeat (3) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
